// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave-select arbiter.
// Holds the FSM state enum, the default timing constants and a helper
// that sizes the shared cycle counter.
package spi_pkg;

    localparam int unsigned SETUP_CYC_DEF   = 1;
    localparam int unsigned GUARD_CYC_DEF   = 2;
    localparam int unsigned TIMEOUT_CYC_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAIT,
        GUARD
    } spi_state_e;

    // Largest of the three cycle parameters; the shared counter must hold it.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter width for values 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin selector.
//   req   : request vector
//   last  : requester served most recently (0 or 1)
//   gnt_c : combinational one-hot grant, zero when nothing is requested
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt_c
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt_c = 2'b00;
        case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = last ? 2'b01 : 2'b10;
            default: gnt_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/spi_slave_arbiter.sv
// Arbitrates two requesters onto one SPI master with per-slave selects.
//   clk, rst_n          : clock, synchronous active-low reset
//   req, tx_data0/1     : per-requester byte-transfer requests and payloads
//   gnt, done, err      : grant, one-cycle completion pulse, timeout flag
//   rx_data             : received byte, valid while done is high
//   ss_n                : active-low slave selects
//   m_start, m_tx       : start pulse and byte to the SPI master
//   m_done, m_rx        : completion pulse and byte from the SPI master
module spi_slave_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = SETUP_CYC_DEF,
    parameter int unsigned GUARD_CYC   = GUARD_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       err,
    output logic [7:0] rx_data,
    output logic [1:0] ss_n,
    output logic       m_start,
    output logic [7:0] m_tx,
    input  logic       m_done,
    input  logic [7:0] m_rx
);

    localparam int unsigned CNT_MAX = max3(SETUP_CYC, GUARD_CYC, TIMEOUT_CYC);
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

    spi_state_e       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic             sel, sel_d;
    logic             last, last_d;
    logic [1:0]       rr_gnt;

    logic [1:0]       gnt_d, done_d, ss_n_d;
    logic             err_d, m_start_d;
    logic [7:0]       rx_data_d, m_tx_d;

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (last),
        .gnt_c (rr_gnt)
    );

    // Saturating increment shared by the SETUP, WAIT and GUARD phases.
    assign cnt_inc = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + CNT_W'(1);

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sel     <= 1'b0;
            last    <= 1'b1;
            gnt     <= 2'b00;
            done    <= 2'b00;
            err     <= 1'b0;
            rx_data <= 8'h00;
            ss_n    <= 2'b11;
            m_start <= 1'b0;
            m_tx    <= 8'h00;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            sel     <= sel_d;
            last    <= last_d;
            gnt     <= gnt_d;
            done    <= done_d;
            err     <= err_d;
            rx_data <= rx_data_d;
            ss_n    <= ss_n_d;
            m_start <= m_start_d;
            m_tx    <= m_tx_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sel_d     = sel;
        last_d    = last;
        gnt_d     = gnt;
        ss_n_d    = ss_n;
        m_tx_d    = m_tx;
        rx_data_d = rx_data;
        done_d    = 2'b00;
        err_d     = 1'b0;
        m_start_d = 1'b0;

        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    sel_d  = rr_gnt[1];
                    gnt_d  = rr_gnt;
                    ss_n_d = ~rr_gnt;
                    m_tx_d = rr_gnt[1] ? tx_data1 : tx_data0;
                    cnt_d  = '0;
                    if (SETUP_CYC == 0) begin
                        state_d   = START;
                        m_start_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                    state_d   = START;
                    m_start_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // Completion or timeout: pulse done and release the slave together.
                if (m_done || (cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
                    done_d    = sel ? 2'b10 : 2'b01;
                    err_d     = !m_done;
                    rx_data_d = m_done ? m_rx : 8'h00;
                    gnt_d     = 2'b00;
                    ss_n_d    = 2'b11;
                    last_d    = sel;
                    cnt_d     = '0;
                    state_d   = (GUARD_CYC == 0) ? IDLE : GUARD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            GUARD: begin
                if (cnt == CNT_W'(GUARD_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                ss_n_d  = 2'b11;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_slave_arbiter.sv
// Self-checking bench for spi_slave_arbiter: directed scenarios plus a
// randomized run, checked against a transaction-level round-robin model.
module tb_spi_slave_arbiter;

    localparam int unsigned SETUP_CYC   = 1;
    localparam int unsigned GUARD_CYC   = 2;
    localparam int unsigned TIMEOUT_CYC = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] tx_data0, tx_data1;
    logic [1:0] gnt, done, ss_n;
    logic       err, m_start, m_done;
    logic [7:0] rx_data, m_tx, m_rx;

    int checks = 0;
    int errors = 0;
    int mstart_cnt = 0;
    int gap_last = 0;
    logic [1:0] gnt_seen;
    bit last_served;

    spi_slave_arbiter #(
        .SETUP_CYC   (SETUP_CYC),
        .GUARD_CYC   (GUARD_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .tx_data0 (tx_data0),
        .tx_data1 (tx_data1),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rx_data  (rx_data),
        .ss_n     (ss_n),
        .m_start  (m_start),
        .m_tx     (m_tx),
        .m_done   (m_done),
        .m_rx     (m_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: a lone requester wins; on a tie the one not served last.
    function automatic int pick(input logic [1:0] r, input bit last);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return last ? 0 : 1;
    endfunction

    // Continuous properties: selects mirror grant, never two slaves selected.
    always @(negedge clk) begin
        logic [1:0] inv_gnt;
        if (rst_n === 1'b1) begin
            inv_gnt = ~gnt;
            check("ss_n_mirrors_gnt", {30'd0, ss_n}, {30'd0, inv_gnt});
            check("ss_n_at_most_one_low", {31'd0, ($countones(~ss_n) <= 1)}, 32'd1);
            if (m_start === 1'b1) mstart_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer from the requester's view, ending in the done cycle.
    task automatic xfer(input logic [1:0] r, input bit respond, input int delay,
                        input bit drop, input logic [7:0] rxval, input bit loopback,
                        input string tag);
        int         w, n;
        logic [1:0] oh;
        logic [7:0] exp_tx, exp_rx;
        req        = r;
        w          = pick(r, last_served);
        oh         = (w == 1) ? 2'b10 : 2'b01;
        exp_tx     = (w == 1) ? tx_data1 : tx_data0;
        mstart_cnt = 0;

        n = 0;
        while (n < 50) begin
            tick();
            n++;
            if (gnt != 2'b00) break;
        end
        gap_last = n;
        gnt_seen = gnt;
        check({tag, "_gnt"}, {30'd0, gnt}, {30'd0, oh});
        check({tag, "_ss_n"}, {30'd0, ss_n}, {30'd0, ~oh});
        check({tag, "_m_tx_latched"}, {24'd0, m_tx}, {24'd0, exp_tx});

        n = 0;
        while (m_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_setup_len"}, n, SETUP_CYC);
        check({tag, "_m_tx_at_start"}, {24'd0, m_tx}, {24'd0, exp_tx});
        if (drop) req = r & ~oh;

        tick();
        check({tag, "_m_start_width"}, {31'd0, m_start}, 32'd0);

        if (respond) begin
            repeat (delay) tick();
            check({tag, "_no_early_done"}, {30'd0, done}, 32'd0);
            exp_rx = loopback ? m_tx : rxval;
            m_rx   = exp_rx;
            m_done = 1'b1;
            tick();
            m_done = 1'b0;
            m_rx   = 8'($urandom);
        end else begin
            exp_rx = 8'h00;
            n = 0;
            while (done == 2'b00 && n < 200) begin
                tick();
                n++;
            end
            check({tag, "_timeout_len"}, n, TIMEOUT_CYC);
        end
        check({tag, "_done"}, {30'd0, done}, {30'd0, oh});
        check({tag, "_err"}, {31'd0, err}, {31'd0, !respond});
        check({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, exp_rx});
        check({tag, "_ss_n_released"}, {30'd0, ss_n}, 32'd3);
        check({tag, "_gnt_released"}, {30'd0, gnt}, 32'd0);
        check({tag, "_one_m_start"}, mstart_cnt, 1);
        last_served = (w == 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (2) tick();
        check("rst_ss_n", {30'd0, ss_n}, 32'd3);
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_done", {30'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_m_start", {31'd0, m_start}, 32'd0);
        check("rst_m_tx", {24'd0, m_tx}, 32'd0);
        last_served = 1'b1;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [1:0] order [4];
        int n;
        order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
        rst_n = 1'b0; req = 2'b00; m_done = 1'b0; m_rx = 8'h00;
        tx_data0 = 8'h00; tx_data1 = 8'h00;
        do_reset();

        // Single transfer with the master looping the byte back.
        tx_data0 = 8'hA5; tx_data1 = 8'h3C;
        xfer(2'b01, 1'b1, 3, 1'b0, 8'h00, 1'b1, "loopback");
        req = 2'b00;

        // Stray m_done in GUARD, then in IDLE.
        m_done = 1'b1; tick(); m_done = 1'b0;
        check("spur_guard_done", {30'd0, done}, 32'd0);
        check("spur_guard_gnt", {30'd0, gnt}, 32'd0);
        repeat (3) tick();
        m_done = 1'b1; m_rx = 8'hFF; tick(); m_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("spur_idle_done", {30'd0, done}, 32'd0);
            check("spur_idle_ss_n", {30'd0, ss_n}, 32'd3);
            tick();
        end

        // Both requesting continuously from reset: strict alternation.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tx_data0 = 8'($urandom); tx_data1 = 8'($urandom);
            xfer(2'b11, 1'b1, $urandom_range(0, 4), 1'b0, 8'($urandom), 1'b0, "rr_held");
            check("rr_order", {30'd0, gnt_seen}, {30'd0, order[i]});
            if (i > 0) check("rr_guard_gap", {31'd0, (gap_last >= GUARD_CYC)}, 32'd1);
        end
        req = 2'b00;

        // Master never answers.
        tx_data1 = 8'h5A;
        xfer(2'b10, 1'b0, 0, 1'b0, 8'h00, 1'b0, "timeout");

        // Requester withdraws while the transfer is in flight.
        tx_data0 = 8'h81;
        xfer(2'b01, 1'b1, 2, 1'b1, 8'h7E, 1'b0, "drop_req");
        req = 2'b00;
        repeat (4) tick();

        // Reset while waiting on the master.
        req = 2'b01;
        n = 0;
        while (m_start !== 1'b1 && n < 20) begin tick(); n++; end
        check("rst_mid_reached_start", {31'd0, m_start}, 32'd1);
        tick(); tick();
        rst_n = 1'b0;
        req   = 2'b00;
        tick();
        check("rst_mid_ss_n", {30'd0, ss_n}, 32'd3);
        check("rst_mid_gnt", {30'd0, gnt}, 32'd0);
        check("rst_mid_done", {30'd0, done}, 32'd0);
        last_served = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_mid_no_done", {30'd0, done}, 32'd0);
        end
        xfer(2'b10, 1'b1, 1, 1'b0, 8'($urandom), 1'b0, "post_rst_only1");
        req = 2'b00;
        do_reset();
        xfer(2'b11, 1'b1, 1, 1'b0, 8'($urandom), 1'b0, "post_rst_tie");
        check("post_rst_tie_winner", {30'd0, gnt_seen}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 20; i++) begin
            tx_data0 = 8'($urandom); tx_data1 = 8'($urandom);
            xfer(2'($urandom_range(1, 3)), ($urandom_range(0, 5) != 0),
                 $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                 8'($urandom), 1'($urandom_range(0, 1)), "rand");
        end
        req = 2'b00;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
